pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
- Consumes the hazard request signals and drives the per-stage stall/flush enables of the 5-stage pipeline (F, D, E, M, W).
- Request sources:
  - load-use detector (lwstall)
  - branch resolution in EX (PCSrcE)
  - data-memory handshake in MEM (MemReqM/MemReadyM)
- Tracks multi-cycle memory waits with a small FSM and timeout counter, and flags protocol errors.

Parameters:
- TO_WIDTH, 8: width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200: maximum consecutive MEM_WAIT cycles before MemTimeout is raised; legal range 1..2^TO_WIDTH-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- lwstall  in  1  load-use hazard: load in EX, dependent instruction in D.
- PCSrcE  in  1  taken branch/jump resolved in EX.
- MemReqM  in  1  MEM-stage instruction accesses data memory.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID register.
- StallE  out  1  hold ID/EX register.
- StallM  out  1  hold EX/MEM register.
- FlushD  out  1  clear IF/ID (bubble).
- FlushE  out  1  clear ID/EX (bubble).
- FlushW  out  1  clear MEM/WB (bubble into WB).
- MemWaitState  out  1  FSM is in MEM_WAIT.
- MemTimeout  out  1  sticky: memory wait exceeded MEM_TIMEOUT.
- HazardErr  out  1  sticky: lwstall held 2 consecutive non-wait cycles.

Behaviour:
- Reset:
  - clk single clock; rst is synchronous, active-high.
  - While rst=1, all Stall*/Flush* outputs are forced to 0.
  - On the reset edge: FSM→RUN, timeout counter=0, MemTimeout=0, HazardErr=0, lw_prev=0.
  - Reset mid-wait abandons the wait with no pending state.
- Stall/flush outputs are combinational from the inputs and current state; they take effect on the same edge.
- Memory wait is active when MemReqM=1 && MemReadyM=0. This is priority 1, over everything else:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - lwstall and PCSrcE are ignored; they are re-evaluated once the wait ends because the pipeline is frozen.
- Priority 2, PCSrcE=1 (no memory wait): FlushD=1, FlushE=1, all stalls 0. This overrides lwstall, because a wrong-path instruction in D is discarded.
- Priority 3, lwstall=1: StallF=1, StallD=1, FlushE=1, others 0.
- Otherwise all outputs are 0.
- FSM states:
  - RUN → MEM_WAIT when memory wait is active.
  - MEM_WAIT → RUN on MemReadyM=1 or MemReqM=0.
  - MemWaitState=1 exactly in MEM_WAIT.
  - The MemReadyM=1 cycle is a normal (non-stalled) cycle.
- Timeout counter:
  - Clears on entering RUN.
  - Increments each cycle memory wait is active, saturating at 2^TO_WIDTH-1.
  - When count reaches MEM_TIMEOUT while still waiting, MemTimeout sets to 1 and stays set until rst. The stall continues; no forced release.
- HazardErr:
  - lw_prev registers (lwstall && no memory wait && !PCSrcE).
  - HazardErr sets if lw_prev=1 and the same condition holds again the next cycle. A correct detector drops lwstall after one bubble, since the load advances to MEM.
  - Sticky until rst; outputs still follow the priority rules.
- MemReadyM with MemReqM=0 is ignored.

Optional Feature:
- STALL_PERF_CNT_EN
- When defined, adds 32-bit outputs perf_lw_bubbles, perf_br_flushes and perf_mem_wait_cycles.
  - Each counts the cycles in which its priority rule is the one applied.
  - All reset to 0 on rst and wrap modulo 2^32.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

Test Plan:
- After reset, lwstall=1 for 1 cycle → StallF=StallD=FlushE=1 that cycle only, then all 0; HazardErr=0.
- PCSrcE=1 and lwstall=1 in the same cycle → FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1 and MemReadyM=0 for 3 cycles, then MemReadyM=1:
  - cycles 1-3: StallF/D/E/M=1, FlushW=1, MemWaitState=1, with lwstall=1 and PCSrcE=1 also driven, which is ignored.
  - cycle 4: all stalls 0, FSM back in RUN.
- MEM_TIMEOUT=5, memory wait held 8 cycles → MemTimeout rises on the 5th wait cycle, remains 1 after the wait ends, clears only on rst.
- lwstall held 2 consecutive cycles, no memory wait → HazardErr=1 from the cycle after the 2nd; rst mid-MEM_WAIT → next cycle outputs 0, MemWaitState=0, MemTimeout=0.
- With STALL_PERF_CNT_EN: 2 lw bubbles, 1 branch flush, 4 wait cycles → counters read 2/1/4.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Hazard stall/flush controller for a 5-stage pipeline with memory-wait FSM, timeout and protocol checks.
// Optional macro STALL_PERF_CNT_EN adds per-rule cycle counters.
module pipeline_stall_ctrl #(
  parameter int TO_WIDTH    = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic lwstall,
  input  logic PCSrcE,
  input  logic MemReqM,
  input  logic MemReadyM,
  output logic StallF,
  output logic StallD,
  output logic StallE,
  output logic StallM,
  output logic FlushD,
  output logic FlushE,
  output logic FlushW,
  output logic MemWaitState,
  output logic MemTimeout,
  output logic HazardErr
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_lw_bubbles,
  output logic [31:0] perf_br_flushes,
  output logic [31:0] perf_mem_wait_cycles
`endif
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [TO_WIDTH-1:0] TO_MAX  = '1;

  state_t              r_state;
  logic [TO_WIDTH-1:0] r_to_cnt;
  logic                r_timeout;
  logic                r_hazard_err;
  logic                r_lw_prev;

  logic w_mem_wait;
  logic w_br_flush;
  logic w_lw_bubble;

  assign w_mem_wait  = MemReqM & ~MemReadyM;
  assign w_br_flush  = ~w_mem_wait & PCSrcE;
  assign w_lw_bubble = ~w_mem_wait & ~PCSrcE & lwstall;

  // Stall/flush act on the same edge, so they stay combinational; reset masks them.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (!rst) begin
      if (w_mem_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lwstall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= RUN;
      r_to_cnt     <= '0;
      r_timeout    <= 1'b0;
      r_hazard_err <= 1'b0;
      r_lw_prev    <= 1'b0;
    end else begin
      r_lw_prev <= w_lw_bubble;
      if (r_lw_prev && w_lw_bubble)
        r_hazard_err <= 1'b1;
      case (r_state)
        RUN:      if (w_mem_wait) r_state <= MEM_WAIT;
        MEM_WAIT: if (!w_mem_wait) r_state <= RUN;
        default:  r_state <= RUN;
      endcase
      // Count consecutive wait cycles; flag on the cycle that makes the count reach MEM_TIMEOUT.
      if (w_mem_wait) begin
        if (r_to_cnt != TO_MAX)
          r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt >= TO_LAST)
          r_timeout <= 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign MemWaitState = (r_state == MEM_WAIT);
  assign MemTimeout   = r_timeout;
  assign HazardErr    = r_hazard_err;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_perf_lw;
  logic [31:0] r_perf_br;
  logic [31:0] r_perf_mw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_lw <= '0;
      r_perf_br <= '0;
      r_perf_mw <= '0;
    end else begin
      if (w_lw_bubble) r_perf_lw <= r_perf_lw + 32'd1;
      if (w_br_flush)  r_perf_br <= r_perf_br + 32'd1;
      if (w_mem_wait)  r_perf_mw <= r_perf_mw + 32'd1;
    end
  end

  assign perf_lw_bubbles      = r_perf_lw;
  assign perf_br_flushes      = r_perf_br;
  assign perf_mem_wait_cycles = r_perf_mw;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: vector table for priority rules plus multi-cycle sequences.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic lwstall, PCSrcE, MemReqM, MemReadyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic MemWaitState, MemTimeout, HazardErr;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lw_bubbles, perf_br_flushes, perf_mem_wait_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.TO_WIDTH(8), .MEM_TIMEOUT(5)) dut (
    .clk(clk), .rst(rst),
    .lwstall(lwstall), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemWaitState(MemWaitState), .MemTimeout(MemTimeout), .HazardErr(HazardErr)
`ifdef STALL_PERF_CNT_EN
    , .perf_lw_bubbles(perf_lw_bubbles), .perf_br_flushes(perf_br_flushes),
    .perf_mem_wait_cycles(perf_mem_wait_cycles)
`endif
  );

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] w_so;
  assign w_so = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] SO_NONE = 7'b0000000;
  localparam logic [6:0] SO_LW   = 7'b1100010;
  localparam logic [6:0] SO_BR   = 7'b0000110;
  localparam logic [6:0] SO_MEM  = 7'b1111001;

  typedef struct {
    logic       lw;
    logic       pc;
    logic       req;
    logic       rdy;
    logic [6:0] exp_so;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic lw, input logic pc, input logic req, input logic rdy);
    @(negedge clk);
    lwstall = lw; PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    lwstall = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{0, 0, 0, 0, SO_NONE};
    vecs[1]  = '{1, 0, 0, 0, SO_LW};
    vecs[2]  = '{0, 0, 0, 0, SO_NONE};
    vecs[3]  = '{0, 1, 0, 0, SO_BR};
    vecs[4]  = '{1, 1, 0, 0, SO_BR};
    vecs[5]  = '{0, 0, 1, 0, SO_MEM};
    vecs[6]  = '{1, 1, 1, 0, SO_MEM};
    vecs[7]  = '{0, 0, 1, 1, SO_NONE};
    vecs[8]  = '{0, 0, 0, 1, SO_NONE};
    vecs[9]  = '{1, 0, 1, 1, SO_LW};
    vecs[10] = '{0, 1, 1, 1, SO_BR};
    vecs[11] = '{0, 0, 0, 0, SO_NONE};

    rst = 1'b1;
    lwstall = 1; PCSrcE = 1; MemReqM = 1; MemReadyM = 0;
    #2;
    chk("outputs_forced_in_reset", {25'd0, w_so}, {25'd0, SO_NONE});
    tick();
    tick();
    chk("reset_memwait", {31'd0, MemWaitState}, 32'd0);
    chk("reset_timeout", {31'd0, MemTimeout}, 32'd0);
    chk("reset_hazard",  {31'd0, HazardErr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].lw, vecs[i].pc, vecs[i].req, vecs[i].rdy);
      chk($sformatf("vec%0d_so", i), {25'd0, w_so}, {25'd0, vecs[i].exp_so});
      tick();
    end
    chk("table_no_hazard", {31'd0, HazardErr}, 32'd0);
    chk("table_no_timeout", {31'd0, MemTimeout}, 32'd0);

    // Single load-use bubble
    do_reset();
    drive(1, 0, 0, 0);
    chk("lw1_so", {25'd0, w_so}, {25'd0, SO_LW});
    tick();
    drive(0, 0, 0, 0);
    chk("lw1_after_so", {25'd0, w_so}, {25'd0, SO_NONE});
    tick();
    chk("lw1_hazard", {31'd0, HazardErr}, 32'd0);

    // Three-cycle memory wait with lwstall/PCSrcE ignored, then ready
    for (int k = 1; k <= 3; k++) begin
      drive(1, 1, 1, 0);
      chk($sformatf("mw%0d_so", k), {25'd0, w_so}, {25'd0, SO_MEM});
      if (k > 1) chk($sformatf("mw%0d_state", k), {31'd0, MemWaitState}, 32'd1);
      tick();
    end
    drive(0, 0, 1, 1);
    chk("mw4_so", {25'd0, w_so}, {25'd0, SO_NONE});
    chk("mw4_state_pre", {31'd0, MemWaitState}, 32'd1);
    tick();
    chk("mw4_state_run", {31'd0, MemWaitState}, 32'd0);

    // Timeout after 5 of 8 wait cycles; sticky until reset
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drive(0, 0, 1, 0);
      tick();
      chk($sformatf("to_wait%0d", k), {31'd0, MemTimeout}, (k >= 5) ? 32'd1 : 32'd0);
    end
    drive(0, 0, 0, 0);
    chk("to_release_so", {25'd0, w_so}, {25'd0, SO_NONE});
    tick();
    chk("to_sticky", {31'd0, MemTimeout}, 32'd1);
    chk("to_release_state", {31'd0, MemWaitState}, 32'd0);
    do_reset();
    #2;
    chk("to_cleared_by_reset", {31'd0, MemTimeout}, 32'd0);

    // lwstall held two cycles -> HazardErr
    drive(1, 0, 0, 0);
    tick();
    chk("hz_after_first", {31'd0, HazardErr}, 32'd0);
    drive(1, 0, 0, 0);
    chk("hz_second_so", {25'd0, w_so}, {25'd0, SO_LW});
    tick();
    chk("hz_set", {31'd0, HazardErr}, 32'd1);
    drive(0, 1, 0, 0);
    chk("hz_priority_kept", {25'd0, w_so}, {25'd0, SO_BR});
    tick();
    chk("hz_sticky", {31'd0, HazardErr}, 32'd1);

    // Reset in the middle of a memory wait
    drive(0, 0, 1, 0);
    tick();
    drive(0, 0, 1, 0);
    tick();
    chk("rmw_in_wait", {31'd0, MemWaitState}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("rmw_forced_so", {25'd0, w_so}, {25'd0, SO_NONE});
    tick();
    @(negedge clk);
    rst = 1'b0;
    lwstall = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    #2;
    chk("rmw_so", {25'd0, w_so}, {25'd0, SO_NONE});
    chk("rmw_state", {31'd0, MemWaitState}, 32'd0);
    chk("rmw_timeout", {31'd0, MemTimeout}, 32'd0);
    chk("rmw_hazard", {31'd0, HazardErr}, 32'd0);

`ifdef STALL_PERF_CNT_EN
    do_reset();
    #2;
    chk("perf_reset_lw", perf_lw_bubbles, 32'd0);
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 1); tick();
    chk("perf_lw", perf_lw_bubbles, 32'd2);
    chk("perf_br", perf_br_flushes, 32'd1);
    chk("perf_mw", perf_mem_wait_cycles, 32'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
